// File: rtl/acc_bcd_display.sv
// Accumulator read-out: serial double-dabble binary-to-BCD conversion feeding a
// time-multiplexed, common-anode 4-digit 7-segment display with blanking and overflow dashes.
module acc_bcd_display #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_in,
  input  logic [15:0] acc_in,
  output logic        busy_out,
  output logic [19:0] bcd_out,
  output logic        ovf_out,
  output logic [6:0]  seg_out,
  output logic [3:0]  an_out
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam int unsigned      CntW   = $clog2(SCAN_DIV);
  localparam logic [CntW-1:0]  CntMax = CntW'(SCAN_DIV - 1);

  localparam logic [6:0] SegZero  = 7'b1000000;
  localparam logic [6:0] SegDash  = 7'b0111111;
  localparam logic [6:0] SegBlank = 7'b1111111;

  logic [1:0]      state_q, state_d;
  logic [15:0]     shift_q, shift_d;
  logic [19:0]     work_q, work_d;
  logic [4:0]      bits_q, bits_d;
  logic            busy_q, busy_d;
  logic [19:0]     bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic [19:0]     work_adj;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      dig_q, dig_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic [3:0]      nib;
  logic            lz;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    work_adj = work_q;
    for (int i = 0; i < 5; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    work_d  = work_q;
    bits_d  = bits_q;
    busy_d  = busy_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (load_in) begin
          shift_d = acc_in;
          work_d  = '0;
          bits_d  = 5'd16;
          busy_d  = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        work_d  = {work_adj[18:0], shift_q[15]};
        shift_d = {shift_q[14:0], 1'b0};
        bits_d  = bits_q - 5'd1;
        if (bits_q == 5'd1) begin
          state_d = StDone;
        end
      end
      StDone: begin
        bcd_d   = work_q;
        ovf_d   = (work_q[19:16] != 4'd0);
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // Display registers are computed from next-state index and result so they never lag.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    dig_d = dig_q;
    if (cnt_q == CntMax) begin
      cnt_d = '0;
      dig_d = dig_q + 2'd1;
    end

    nib = bcd_d[3:0];
    lz  = 1'b0;
    case (dig_d)
      2'd0: begin
        nib = bcd_d[3:0];
        lz  = 1'b0;
      end
      2'd1: begin
        nib = bcd_d[7:4];
        lz  = (bcd_d[15:4] == 12'd0);
      end
      2'd2: begin
        nib = bcd_d[11:8];
        lz  = (bcd_d[15:8] == 8'd0);
      end
      default: begin
        nib = bcd_d[15:12];
        lz  = (bcd_d[15:12] == 4'd0);
      end
    endcase

    if (ovf_d) begin
      seg_d = SegDash;
    end else if (BLANK_LZ && lz) begin
      seg_d = SegBlank;
    end else begin
      seg_d = seg7(nib);
    end
    an_d = ~(4'b0001 << dig_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      work_q  <= '0;
      bits_q  <= '0;
      busy_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      dig_q   <= '0;
      seg_q   <= SegZero;
      an_q    <= 4'b1110;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      work_q  <= work_d;
      bits_q  <= bits_d;
      busy_q  <= busy_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign busy_out = busy_q;
  assign bcd_out  = bcd_q;
  assign ovf_out  = ovf_q;
  assign seg_out  = seg_q;
  assign an_out   = an_q;

endmodule

// File: tb/tb_acc_bcd_display.sv
// Directed bench for acc_bcd_display: two instances (blanking on/off) share stimulus.
module tb_acc_bcd_display;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_in = 1'b0;
  logic [15:0] acc_in = '0;

  logic        busy_a, busy_b;
  logic [19:0] bcd_a, bcd_b;
  logic        ovf_a, ovf_b;
  logic [6:0]  seg_a, seg_b;
  logic [3:0]  an_a, an_b;

  int passes = 0;
  int fails  = 0;
  int total  = 0;
  int cyc;

  acc_bcd_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .reset(reset), .load_in(load_in), .acc_in(acc_in),
    .busy_out(busy_a), .bcd_out(bcd_a), .ovf_out(ovf_a), .seg_out(seg_a), .an_out(an_a)
  );

  acc_bcd_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .reset(reset), .load_in(load_in), .acc_in(acc_in),
    .busy_out(busy_b), .bcd_out(bcd_b), .ovf_out(ovf_b), .seg_out(seg_b), .an_out(an_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy_a && n < 40) begin
      n++;
      tick();
    end
  endtask

  // Returns number of cycles busy stayed high after the load edge (inclusive).
  task automatic convert(input logic [15:0] v, output int n);
    load_in = 1'b1;
    acc_in  = v;
    tick();
    load_in = 1'b0;
    wait_idle(n);
  endtask

  task automatic show(input int d, input logic [6:0] exp_a, input logic [6:0] exp_b);
    logic [3:0] tgt;
    int w;
    tgt = ~(4'b0001 << d);
    w = 0;
    while (an_a !== tgt && w < 20) begin
      tick();
      w++;
    end
    chk("anode", {28'd0, an_a}, {28'd0, tgt});
    chk("seg_blank_on", {25'd0, seg_a}, {25'd0, exp_a});
    chk("seg_blank_off", {25'd0, seg_b}, {25'd0, exp_b});
  endtask

  initial begin
    logic [3:0] exp_an;

    // Reset values
    tick();
    tick();
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_bcd", {12'd0, bcd_a}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_a}, 32'd0);
    chk("rst_an", {28'd0, an_a}, 32'hE);
    chk("rst_seg", {25'd0, seg_a}, 32'h40);
    chk("rst_b", {busy_b, ovf_b, an_b, bcd_b}, {2'b00, 4'hE, 20'h0});
    reset = 1'b0;

    // 1234: 17-cycle busy, digits 4,3,2,1
    convert(16'd1234, cyc);
    chk("busy_len_1234", cyc, 32'd17);
    chk("bcd_1234", {12'd0, bcd_a}, 32'h01234);
    chk("bcd_1234_b", {12'd0, bcd_b}, 32'h01234);
    chk("ovf_1234", {31'd0, ovf_a}, 32'd0);
    show(0, 7'b0011001, 7'b0011001);
    show(1, 7'b0110000, 7'b0110000);
    show(2, 7'b0100100, 7'b0100100);
    show(3, 7'b1111001, 7'b1111001);

    // 65535: overflow dashes everywhere
    convert(16'd65535, cyc);
    chk("bcd_65535", {12'd0, bcd_a}, 32'h65535);
    chk("ovf_65535", {30'd0, ovf_a, ovf_b}, 32'd3);
    for (int d = 0; d < 4; d++) show(d, 7'b0111111, 7'b0111111);

    // 7: leading-zero blanking vs. plain zeros
    convert(16'd7, cyc);
    chk("bcd_7", {12'd0, bcd_a}, 32'h00007);
    chk("ovf_7", {31'd0, ovf_a}, 32'd0);
    show(0, 7'b1111000, 7'b1111000);
    for (int d = 1; d < 4; d++) show(d, 7'b1111111, 7'b1000000);

    // 500 with a 9999 load while busy: second load dropped, old result held
    load_in = 1'b1;
    acc_in  = 16'd500;
    tick();
    load_in = 1'b0;
    tick();
    tick();
    load_in = 1'b1;
    acc_in  = 16'd9999;
    tick();
    load_in = 1'b0;
    chk("busy_mid", {31'd0, busy_a}, 32'd1);
    chk("bcd_held", {12'd0, bcd_a}, 32'h00007);
    wait_idle(cyc);
    chk("busy_len_500", cyc, 32'd14);
    chk("bcd_500", {12'd0, bcd_a}, 32'h00500);
    convert(16'd9999, cyc);
    chk("bcd_9999", {12'd0, bcd_a}, 32'h09999);

    // Load presented during the DONE cycle is dropped
    load_in = 1'b1;
    acc_in  = 16'd55;
    tick();
    load_in = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    load_in = 1'b1;
    acc_in  = 16'd123;
    tick();
    load_in = 1'b0;
    chk("done_busy", {31'd0, busy_a}, 32'd0);
    tick();
    chk("done_ignored", {31'd0, busy_a}, 32'd0);
    chk("bcd_55", {12'd0, bcd_a}, 32'h00055);

    // Reset mid-conversion
    load_in = 1'b1;
    acc_in  = 16'd4321;
    tick();
    load_in = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_bcd", {12'd0, bcd_a}, 32'd0);
    chk("abort_an", {28'd0, an_a}, 32'hE);
    chk("abort_seg", {25'd0, seg_a}, 32'h40);

    // Free-running scan: each anode held exactly 4 cycles
    for (int i = 1; i < 16; i++) begin
      tick();
      exp_an = ~(4'b0001 << ((i / 4) % 4));
      chk("scan_an", {28'd0, an_a}, {28'd0, exp_an});
    end

    convert(16'd42, cyc);
    chk("bcd_42", {12'd0, bcd_a}, 32'h00042);
    convert(16'd10000, cyc);
    chk("bcd_10000", {12'd0, bcd_a}, 32'h10000);
    chk("ovf_10000", {31'd0, ovf_a}, 32'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/acc_bcd_display.md
Name: acc_bcd_display

Overview:
Read-side consumer of the calculator's 16-bit accumulator value.
- On a load strobe, converts the unsigned binary value to 5 BCD digits using sequential shift-and-add-3 (double-dabble), one bit per clock.
- Holds the converted result and drives a 4-digit, time-multiplexed, common-anode 7-segment display, with leading-zero blanking and an overflow indication.
- Sits downstream of the accumulator register; it is the output end of the datapath whose input end loads keypad digits and ALU results into the accumulator.

Parameters:
- SCAN_DIV, 50000: clock cycles each digit stays lit before the scan advances; legal range is 2 or more.
- BLANK_LZ, 1: 1 enables leading-zero blanking; 0 shows all digits including leading zeros.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load_in  input  1  single-cycle strobe; captures acc_in and starts a conversion.
- acc_in  input  16  unsigned accumulator value.
- busy_out  output  1  high while a conversion is in progress.
- bcd_out  output  20  registered result; [19:16] is ten-thousands, [3:0] is units.
- ovf_out  output  1  high when the displayed value exceeds 9999, i.e. bcd_out[19:16] != 0.
- seg_out  output  7  active-low segments, ordered {g,f,e,d,c,b,a}.
- an_out  output  4  active-low digit enables, one-hot; an_out[0] is the units digit.

Behaviour:
Reset values (any cycle with reset=1):
- state=IDLE, busy_out=0, bcd_out=0, ovf_out=0.
- Scan counter=0, digit index=0, an_out=4'b1110, seg_out=7'b1000000 (glyph "0").
- Reset during SHIFT aborts the conversion; the partial result is discarded.

Conversion FSM (IDLE, SHIFT, DONE):
- IDLE: when load_in=1, capture acc_in into a 16-bit shift register, clear the 20-bit BCD working register, set the bit count to 16, assert busy_out, and go to SHIFT.
- SHIFT, once per cycle:
  - Add 3 to every working nibble whose value is 5 or more.
  - Shift {bcd_work, shift_reg} left by 1.
  - Decrement the bit count; after the 16th shift, go to DONE.
- DONE: copy bcd_work to bcd_out, update ovf_out, deassert busy_out, go to IDLE.
- Latency: with load_in sampled at edge N, busy_out is high after edges N..N+16, and bcd_out/ovf_out are updated at edge N+17 and low-busy from then on.
- load_in while busy_out=1 is ignored; no queueing.
- load_in in the same cycle that DONE completes is also ignored. A new load is accepted only in IDLE.
- bcd_out holds its previous value throughout a conversion; the display never shows intermediate values.

Display scan:
- The scan counter runs 0..SCAN_DIV-1 and wraps.
- On each wrap, the digit index advances 0→1→2→3→0 and an_out moves to the next one-hot position.
- Digit d shows bcd_out[4d+3:4d], decoded to 7 segments. The seg_out/an_out registers update in the same cycle as the index change.
- Overflow: when ovf_out=1, every digit shows a dash (seg_out=7'b0111111) regardless of value.
- Blanking: when BLANK_LZ=1, digit d>0 is blanked (seg_out=7'b1111111, anode still enabled) if digit d and all higher digits are 0. Digit 0 is never blanked.
- Nibble values 10..15 cannot occur; if they do, the decoder outputs blank.
- The scan runs continuously and is independent of the conversion FSM.

Test Plan:
- Reset then load acc_in=16'd1234: busy_out high for 17 cycles; bcd_out=20'h01234 and ovf_out=0 at edge N+17. With SCAN_DIV=4, digit 0 shows "4" (7'b0011001) and digit 3 shows "1" (7'b1111001).
- Load 16'd65535: bcd_out=20'h65535, ovf_out=1, all four digits seg_out=7'b0111111.
- Load 16'd7 with BLANK_LZ=1: digit 0 shows 7'b1111000; digits 1–3 are 7'b1111111. With BLANK_LZ=0, digits 1–3 show 7'b1000000.
- Load 16'd500, then pulse load_in with 16'd9999 three cycles later (while busy): result is bcd_out=20'h00500; a subsequent load in IDLE gives 20'h09999.
- Load 16'd4321, assert reset at cycle N+8, then release: busy_out=0, bcd_out=0, an_out=4'b1110. A new load of 16'd42 then yields 20'h00042.
- SCAN_DIV=4, free running: an_out steps 1110→1101→1011→0111→1110, holding each value exactly 4 cycles; 10000 → ovf_out=1, bcd_out=20'h10000.
